sad_accum_pipe: RTL and testbench

//  Parametrised multi-lane subtract / absolute-difference unit with block accumulation.
//  Per accepted beat: each lane forms op1_i - op2_i (ABS mode: |op1_i - op2_i|).

---
 rtl/sad_pkg.sv | 27 ++
 rtl/sad_accum_pipe_if.sv | 28 ++
 rtl/sad_lane.sv | 24 ++
 rtl/sad_accum_pipe.sv | 192 +++++++++++++++++++
 tb/tb_sad_accum_pipe.sv | 373 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sad_pkg.sv
// Shared definitions for the multi-lane SAD / difference accumulator.
// Holds the mode encoding, a constant clog2 and the lane-sum width formula.
package sad_pkg;

   typedef enum logic {
      SAD_MODE_SUB = 1'b0,
      SAD_MODE_ABS = 1'b1
   } sad_mode_e;

   function automatic int sad_clog2(input int value);
      int result;
      int rem;
      result = 0;
      rem    = value - 1;
      while (rem > 0) begin
         result = result + 1;
         rem    = rem >> 1;
      end
      return result;
   endfunction

   // Signed width that holds the sum of LANES differences of WIDTH+1 bits each.
   function automatic int sad_sum_w(input int width, input int lanes);
      return width + sad_clog2(lanes) + 1;
   endfunction

endpackage

// File: rtl/sad_accum_pipe_if.sv
// Beat input and block-result output bundle of sad_accum_pipe.
// A beat moves when in_valid && in_ready; a result moves when out_valid && out_ready.
interface sad_accum_pipe_if #(
   parameter int WIDTH = 8,
   parameter int LANES = 4,
   parameter int ACC_W = 16
);
   logic                     in_valid;
   logic                     in_ready;
   logic                     in_last;
   logic                     abs_en;
   logic [LANES*WIDTH-1:0]   op1;
   logic [LANES*WIDTH-1:0]   op2;
   logic                     out_valid;
   logic                     out_ready;
   logic [ACC_W-1:0]         res;
   logic                     ovf;

   modport slave (
      input  in_valid, in_last, abs_en, op1, op2, out_ready,
      output in_ready, out_valid, res, ovf
   );

   modport master (
      output in_valid, in_last, abs_en, op1, op2, out_ready,
      input  in_ready, out_valid, res, ovf
   );
endinterface

// File: rtl/sad_lane.sv
// One lane: WIDTH-bit unsigned difference, or its magnitude in ABS mode.
// Result is WIDTH+1 bits signed so both -(2^WIDTH-1) and +(2^WIDTH-1) fit.
module sad_lane
   import sad_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0]    i_a,
   input  logic [WIDTH-1:0]    i_b,
   input  sad_mode_e           i_mode,
   output logic signed [WIDTH:0] o_diff
);

   logic signed [WIDTH:0] w_sub;

   always_comb begin
      w_sub  = $signed({1'b0, i_a}) - $signed({1'b0, i_b});
      o_diff = w_sub;
      if (i_mode == SAD_MODE_ABS && w_sub[WIDTH]) begin
         o_diff = -w_sub;
      end
   end

endmodule

// File: rtl/sad_accum_pipe.sv
// Multi-lane diff / abs-diff, lane adder and per-block accumulator with a
// valid/ready result port. Define SAD_ACC_SATURATE_EN to clamp instead of wrap.
module sad_accum_pipe
   import sad_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int LANES     = 4,
   parameter int ACC_W     = 16,
   parameter int BLOCK_LEN = 4
) (
   input logic             clk,
   input logic             rst,
   sad_accum_pipe_if.slave bus
);

   localparam int SUM_W = sad_sum_w(WIDTH, LANES);
   localparam int EXT_W = ((ACC_W > SUM_W) ? ACC_W : SUM_W) + 2;
   localparam int CNT_W = (BLOCK_LEN > 1) ? sad_clog2(BLOCK_LEN) : 1;

   logic                    w_adv;
   logic                    w_accept;
   logic                    w_close;
   sad_mode_e               w_in_mode;
   sad_mode_e               w_mode;
   logic signed [WIDTH:0]   w_diff [LANES];
   logic signed [SUM_W-1:0] w_sum;
   logic signed [EXT_W-1:0] w_acc_ext;
   logic signed [EXT_W-1:0] w_sum_ext;
   logic signed [EXT_W-1:0] w_tot;
   logic signed [EXT_W-1:0] w_hi;
   logic signed [EXT_W-1:0] w_lo;
   logic                    w_of;
   logic [ACC_W-1:0]        w_new;

   logic [CNT_W-1:0]        r_cnt;
   sad_mode_e               r_blk_mode;
   logic                    r_s1_valid;
   logic signed [WIDTH:0]   r_s1_diff [LANES];
   logic                    r_s1_close;
   sad_mode_e               r_s1_mode;
   logic                    r_s2_valid;
   logic signed [SUM_W-1:0] r_s2_sum;
   logic                    r_s2_close;
   sad_mode_e               r_s2_mode;
   logic [ACC_W-1:0]        r_acc;
   logic                    r_acc_ovf;
   logic                    r_s3_done;
   logic [ACC_W-1:0]        r_s3_res;
   logic                    r_s3_ovf;
   logic                    r_out_valid;
   logic [ACC_W-1:0]        r_res;
   logic                    r_ovf;

   // Every stage freezes while a finished result waits for its consumer.
   assign w_adv     = !(r_out_valid && !bus.out_ready);
   assign w_accept  = bus.in_valid && w_adv;
   assign w_in_mode = sad_mode_e'(bus.abs_en);
   assign w_mode    = (r_cnt == '0) ? w_in_mode : r_blk_mode;
   assign w_close   = bus.in_last || (r_cnt == CNT_W'(BLOCK_LEN - 1));

   assign bus.in_ready  = w_adv;
   assign bus.out_valid = r_out_valid;
   assign bus.res       = r_res;
   assign bus.ovf       = r_ovf;

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      sad_lane #(.WIDTH(WIDTH)) u_lane (
         .i_a    (bus.op1[g*WIDTH +: WIDTH]),
         .i_b    (bus.op2[g*WIDTH +: WIDTH]),
         .i_mode (w_mode),
         .o_diff (w_diff[g])
      );
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt      <= '0;
         r_blk_mode <= SAD_MODE_SUB;
      end else if (w_accept) begin
         if (r_cnt == '0) begin
            r_blk_mode <= w_in_mode;
         end
         r_cnt <= w_close ? '0 : r_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_s1_close <= 1'b0;
         r_s1_mode  <= SAD_MODE_SUB;
         for (int i = 0; i < LANES; i++) begin
            r_s1_diff[i] <= '0;
         end
      end else if (w_adv) begin
         r_s1_valid <= w_accept;
         if (w_accept) begin
            r_s1_diff  <= w_diff;
            r_s1_close <= w_close;
            r_s1_mode  <= w_mode;
         end
      end
   end

   always_comb begin
      w_sum = '0;
      for (int i = 0; i < LANES; i++) begin
         w_sum = w_sum + SUM_W'(r_s1_diff[i]);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s2_valid <= 1'b0;
         r_s2_sum   <= '0;
         r_s2_close <= 1'b0;
         r_s2_mode  <= SAD_MODE_SUB;
      end else if (w_adv) begin
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_s2_sum   <= w_sum;
            r_s2_close <= r_s1_close;
            r_s2_mode  <= r_s1_mode;
         end
      end
   end

   // Add in a width that cannot overflow, then judge the range for the block's mode.
   always_comb begin
      w_sum_ext = EXT_W'(r_s2_sum);
      if (r_s2_mode == SAD_MODE_ABS) begin
         w_acc_ext = $signed(EXT_W'(r_acc));
         w_hi      = $signed((EXT_W'(1) << ACC_W) - EXT_W'(1));
         w_lo      = '0;
      end else begin
         w_acc_ext = EXT_W'($signed(r_acc));
         w_hi      = $signed((EXT_W'(1) << (ACC_W - 1)) - EXT_W'(1));
         w_lo      = -$signed(EXT_W'(1) << (ACC_W - 1));
      end
      w_tot = w_acc_ext + w_sum_ext;
      w_of  = (w_tot > w_hi) || (w_tot < w_lo);
`ifdef SAD_ACC_SATURATE_EN
      if (w_tot > w_hi) begin
         w_new = w_hi[ACC_W-1:0];
      end else if (w_tot < w_lo) begin
         w_new = w_lo[ACC_W-1:0];
      end else begin
         w_new = w_tot[ACC_W-1:0];
      end
`else
      w_new = w_tot[ACC_W-1:0];
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc     <= '0;
         r_acc_ovf <= 1'b0;
         r_s3_done <= 1'b0;
         r_s3_res  <= '0;
         r_s3_ovf  <= 1'b0;
      end else if (w_adv) begin
         r_s3_done <= r_s2_valid && r_s2_close;
         if (r_s2_valid) begin
            if (r_s2_close) begin
               r_acc     <= '0;
               r_acc_ovf <= 1'b0;
               r_s3_res  <= w_new;
               r_s3_ovf  <= r_acc_ovf || w_of;
            end else begin
               r_acc     <= w_new;
               r_acc_ovf <= r_acc_ovf || w_of;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_res       <= '0;
         r_ovf       <= 1'b0;
      end else if (w_adv) begin
         r_out_valid <= r_s3_done;
         if (r_s3_done) begin
            r_res <= r_s3_res;
            r_ovf <= r_s3_ovf;
         end
      end
   end

endmodule

// File: tb/tb_sad_accum_pipe.sv
// Bench for sad_accum_pipe: a 16-bit and a 10-bit accumulator instance share one
// stimulus stream and are compared against an integer block model.
module tb_sad_accum_pipe;

   localparam int WIDTH     = 8;
   localparam int LANES     = 4;
   localparam int BLOCK_LEN = 4;

   localparam logic [31:0] A_ABS = {8'd255, 8'd0, 8'd10, 8'd123};
   localparam logic [31:0] B_ABS = {8'd0, 8'd255, 8'd10, 8'd200};
   localparam logic [31:0] A_SUB = 32'h7B7B7B7B;
   localparam logic [31:0] B_SUB = 32'hC8C8C8C8;
`ifdef SAD_ACC_SATURATE_EN
   localparam logic [31:0] EXP_T6_10 = 32'd1023;
`else
   localparam logic [31:0] EXP_T6_10 = 32'd1016;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        tb_in_valid;
   logic        tb_in_last;
   logic        tb_abs;
   logic [31:0] tb_op1;
   logic [31:0] tb_op2;
   logic        tb_ready_man;
   logic        tb_ready_rnd;
   logic        rdy_mode;

   always #5 clk = ~clk;

   sad_accum_pipe_if #(.WIDTH(WIDTH), .LANES(LANES), .ACC_W(16)) bus ();
   sad_accum_pipe_if #(.WIDTH(WIDTH), .LANES(LANES), .ACC_W(10)) bus10 ();

   assign bus.in_valid    = tb_in_valid;
   assign bus.in_last     = tb_in_last;
   assign bus.abs_en      = tb_abs;
   assign bus.op1         = tb_op1;
   assign bus.op2         = tb_op2;
   assign bus.out_ready   = rdy_mode ? tb_ready_rnd : tb_ready_man;
   assign bus10.in_valid  = tb_in_valid;
   assign bus10.in_last   = tb_in_last;
   assign bus10.abs_en    = tb_abs;
   assign bus10.op1       = tb_op1;
   assign bus10.op2       = tb_op2;
   assign bus10.out_ready = rdy_mode ? tb_ready_rnd : tb_ready_man;

   sad_accum_pipe #(.WIDTH(WIDTH), .LANES(LANES), .ACC_W(16), .BLOCK_LEN(BLOCK_LEN)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   sad_accum_pipe #(.WIDTH(WIDTH), .LANES(LANES), .ACC_W(10), .BLOCK_LEN(BLOCK_LEN)) u_dut10 (
      .clk (clk),
      .rst (rst),
      .bus (bus10.slave)
   );

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [16:0] exp_q[$];
   logic [10:0] exp10_q[$];
   int          blk_sums[$];
   int          blk_n   = 0;
   bit          blk_abs = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: event did not occur within bound at %0t", name, $time);
   endtask

   // Block result straight from the arithmetic rules, for any accumulator width.
   function automatic logic [16:0] blk_result(input int acc_w, input bit is_abs);
      longint acc;
      longint hi;
      longint lo;
      longint span;
      bit     of;
      acc  = 0;
      of   = 1'b0;
      span = longint'(1) << acc_w;
      if (is_abs) begin
         hi = span - 1;
         lo = 0;
      end else begin
         hi = (span / 2) - 1;
         lo = -(span / 2);
      end
      foreach (blk_sums[k]) begin
         acc = acc + longint'(blk_sums[k]);
         if (acc > hi || acc < lo) begin
            of = 1'b1;
`ifdef SAD_ACC_SATURATE_EN
            acc = (acc > hi) ? hi : lo;
`else
            acc = (((acc - lo) % span) + span) % span + lo;
`endif
         end
      end
      return {of, 16'(acc & (span - 1))};
   endfunction

   function automatic void model_accept(input logic [31:0] a, input logic [31:0] b,
                                        input bit abs_en, input bit last);
      int          s;
      int          d;
      logic [16:0] r16;
      logic [16:0] r10;
      s = 0;
      if (blk_n == 0) blk_abs = abs_en;
      for (int i = 0; i < LANES; i++) begin
         d = int'(a[i*WIDTH +: WIDTH]) - int'(b[i*WIDTH +: WIDTH]);
         s = s + ((blk_abs && d < 0) ? -d : d);
      end
      blk_sums.push_back(s);
      blk_n++;
      if (last || blk_n == BLOCK_LEN) begin
         r16 = blk_result(16, blk_abs);
         r10 = blk_result(10, blk_abs);
         exp_q.push_back(r16);
         exp10_q.push_back({r10[16], r10[9:0]});
         blk_sums.delete();
         blk_n = 0;
      end
   endfunction

   task automatic send_beat(input logic [31:0] a, input logic [31:0] b,
                            input bit abs_en, input bit last);
      bit rdy;
      int guard;
      guard = 0;
      @(negedge clk);
      tb_in_valid = 1'b1;
      tb_op1      = a;
      tb_op2      = b;
      tb_abs      = abs_en;
      tb_in_last  = last;
      forever begin
         #1 rdy = bus.in_ready;
         @(posedge clk);
         if (rdy) begin
            model_accept(a, b, abs_en, last);
            break;
         end
         guard++;
         if (guard > 200) begin
            fail_now("send_beat_accept");
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic idle();
      @(negedge clk);
      tb_in_valid = 1'b0;
      tb_in_last  = 1'b0;
   endtask

   task automatic set_ready(input logic v);
      @(posedge clk);
      #2 tb_ready_man = v;
   endtask

   task automatic wait_result(output bit ok);
      ok = 1'b0;
      for (int g = 0; g < 60; g++) begin
         @(negedge clk);
         if (bus.out_valid) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) fail_now("wait_result");
   endtask

   initial begin
      tb_ready_rnd = 1'b1;
      forever begin
         @(posedge clk);
         #2 tb_ready_rnd = ($urandom_range(0, 3) != 0);
      end
   end

   // Compare process: ordering, values, and hold-while-stalled for both instances.
   initial begin
      logic        prev_hold;
      logic [15:0] prev_res;
      logic        prev_ovf;
      logic [16:0] e16;
      logic [10:0] e10;
      prev_hold = 1'b0;
      prev_res  = '0;
      prev_ovf  = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_hold = 1'b0;
         end else begin
            check("in_ready_rule", 32'(bus.in_ready), 32'(!(bus.out_valid && !bus.out_ready)));
            if (prev_hold) begin
               check("hold_valid", 32'(bus.out_valid), 32'd1);
               check("hold_res", 32'(bus.res), 32'(prev_res));
               check("hold_ovf", 32'(bus.ovf), 32'(prev_ovf));
            end
            if (bus.out_valid && bus.out_ready) begin
               if (exp_q.size() == 0) begin
                  fail_now("unexpected_result16");
               end else begin
                  e16 = exp_q.pop_front();
                  check("res16", 32'(bus.res), 32'(e16[15:0]));
                  check("ovf16", 32'(bus.ovf), 32'(e16[16]));
               end
            end
            if (bus10.out_valid && bus10.out_ready) begin
               if (exp10_q.size() == 0) begin
                  fail_now("unexpected_result10");
               end else begin
                  e10 = exp10_q.pop_front();
                  check("res10", 32'(bus10.res), 32'(e10[9:0]));
                  check("ovf10", 32'(bus10.ovf), 32'(e10[10]));
               end
            end
            prev_hold = bus.out_valid && !bus.out_ready;
            prev_res  = bus.res;
            prev_ovf  = bus.ovf;
         end
      end
   end

   initial begin
      bit ok;
      rst          = 1'b1;
      tb_in_valid  = 1'b0;
      tb_in_last   = 1'b0;
      tb_abs       = 1'b0;
      tb_op1       = '0;
      tb_op2       = '0;
      tb_ready_man = 1'b1;
      rdy_mode     = 1'b0;

      repeat (2) @(negedge clk);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_res", 32'(bus.res), 32'd0);
      check("rst_ovf", 32'(bus.ovf), 32'd0);
      check("rst_res10", 32'(bus10.res), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("rel_in_ready", 32'(bus.in_ready), 32'd1);

      // ABS block with latency measured from the closing beat's accept edge.
      for (int b = 0; b < 4; b++) send_beat(A_ABS, B_ABS, 1'b1, 1'b0);
      @(negedge clk);
      tb_in_valid = 1'b0;
      check("lat_e0", 32'(bus.out_valid), 32'd0);
      @(negedge clk);
      check("lat_e1", 32'(bus.out_valid), 32'd0);
      @(negedge clk);
      check("lat_e2", 32'(bus.out_valid), 32'd0);
      @(negedge clk);
      check("lat_e3", 32'(bus.out_valid), 32'd1);
      check("abs_res", 32'(bus.res), 32'd2348);
      check("abs_ovf", 32'(bus.ovf), 32'd0);

      for (int b = 0; b < 4; b++) send_beat(A_SUB, B_SUB, 1'b0, 1'b0);
      idle();
      wait_result(ok);
      if (ok) begin
         check("sub_res", 32'(bus.res), 32'h0000FB30);
         check("sub_ovf", 32'(bus.ovf), 32'd0);
      end

      send_beat(A_ABS, B_ABS, 1'b1, 1'b0);
      send_beat(A_ABS, B_ABS, 1'b1, 1'b1);
      idle();
      wait_result(ok);
      if (ok) check("last_res", 32'(bus.res), 32'd1174);

      // Count restarts at 0 after in_last; later abs_en changes must not matter.
      send_beat(A_ABS, B_ABS, 1'b1, 1'b0);
      for (int b = 0; b < 3; b++) send_beat(A_ABS, B_ABS, 1'b0, 1'b0);
      idle();
      wait_result(ok);
      if (ok) check("restart_mode_res", 32'(bus.res), 32'd2348);

      send_beat(32'hFFFFFFFF, 32'h0, 1'b1, 1'b0);
      send_beat(32'hFFFFFFFF, 32'h0, 1'b1, 1'b1);
      idle();
      wait_result(ok);
      if (ok) begin
         check("wide_res16", 32'(bus.res), 32'd2040);
         check("wide_ovf16", 32'(bus.ovf), 32'd0);
         check("wrap_res10", 32'(bus10.res), EXP_T6_10);
         check("wrap_ovf10", 32'(bus10.ovf), 32'd1);
      end

      // Backpressure: first result held while the second block queues behind it.
      set_ready(1'b0);
      fork
         begin
            for (int b = 0; b < 4; b++) send_beat(A_ABS, B_ABS, 1'b1, 1'b0);
            for (int b = 0; b < 4; b++) send_beat(A_SUB, B_SUB, 1'b0, 1'b0);
         end
         begin
            repeat (12) @(negedge clk);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
            check("bp_valid", 32'(bus.out_valid), 32'd1);
            check("bp_res", 32'(bus.res), 32'd2348);
            set_ready(1'b1);
         end
      join
      idle();
      wait_result(ok);
      if (ok) check("bp_next_res", 32'(bus.res), 32'h0000FB30);

      // Reset part-way through a block: nothing from it may come out.
      send_beat(A_ABS, B_ABS, 1'b1, 1'b0);
      send_beat(A_ABS, B_ABS, 1'b1, 1'b0);
      @(negedge clk);
      tb_in_valid = 1'b0;
      rst = 1'b1;
      blk_sums.delete();
      blk_n = 0;
      #1;
      check("midrst_valid", 32'(bus.out_valid), 32'd0);
      check("midrst_res", 32'(bus.res), 32'd0);
      check("midrst_ovf", 32'(bus.ovf), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int b = 0; b < 4; b++) send_beat(A_ABS, B_ABS, 1'b1, 1'b0);
      idle();
      wait_result(ok);
      if (ok) check("post_rst_res", 32'(bus.res), 32'd2348);

      // Random beats, gaps, early closes, mode flips and consumer stalls.
      @(posedge clk);
      #2 rdy_mode = 1'b1;
      for (int i = 0; i < 300; i++) begin
         logic [31:0] ra;
         logic [31:0] rb;
         if ($urandom_range(0, 3) == 0) idle();
         ra = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom();
         rb = ($urandom_range(0, 3) == 0) ? 32'h00000000 : $urandom();
         send_beat(ra, rb, 1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0));
      end
      send_beat($urandom(), $urandom(), 1'($urandom_range(0, 1)), 1'b1);
      idle();
      @(posedge clk);
      #2;
      tb_ready_man = 1'b1;
      rdy_mode     = 1'b0;
      for (int g = 0; g < 200; g++) begin
         if (exp_q.size() == 0 && exp10_q.size() == 0) break;
         @(negedge clk);
      end
      if (exp_q.size() != 0 || exp10_q.size() != 0) fail_now("drain_results");
      repeat (5) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
